input_debouncer: RTL

Input conditioner for the devboard's raw mechanical inputs: DIP switches and push buttons. It sits directly upstream of the tester/top-level logic. Each input bit is synchronized to `clk`, debounced with a per-bit stability counter, and presented as a clean level plus one-cycle rise, fall and auto-repeat pulses. Downstream logic (counters, display digit select) consumes only these conditioned signals, never the raw pins.

---
 rtl/input_debouncer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/input_debouncer.sv
// Conditions raw switch/button inputs. Each bit is synchronized and debounced with a
// stability counter. Edge pulses and optional auto-repeat pulses are derived from the clean level.
module input_debouncer #(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned      HOLD_CYCLES     = 50_000_000,
  parameter int unsigned      REPEAT_CYCLES   = 10_000_000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
  parameter logic [WIDTH-1:0] REPEAT_MASK     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rawIn,
  output logic [WIDTH-1:0] stableOut,
  output logic [WIDTH-1:0] risePulse,
  output logic [WIDTH-1:0] fallPulse,
  output logic [WIDTH-1:0] repeatPulse,
  output logic             anyChange
);

  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RptMax = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

  localparam logic [CntW-1:0] CntLast    = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] HoldLast   = RptW'(HOLD_CYCLES - 1);
  localparam logic [RptW-1:0] RepeatLast = RptW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rptState_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] syncQ;
  logic [WIDTH-1:0]                  inSync;

  logic [CntW-1:0]  cntQ [WIDTH];
  logic [CntW-1:0]  cntD [WIDTH];
  logic [WIDTH-1:0] stableD, riseD, fallD;

  rptState_e        stateQ [WIDTH];
  rptState_e        stateD [WIDTH];
  logic [RptW-1:0]  rptQ   [WIDTH];
  logic [RptW-1:0]  rptD   [WIDTH];
  logic [WIDTH-1:0] repeatD;

  assign inSync = syncQ[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      syncQ <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], rawIn};
    end
  end

  // Any mismatch shorter than DEBOUNCE_CYCLES is dropped because the count restarts at 0.
  always_comb begin
    stableD = stableOut;
    riseD   = '0;
    fallD   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cntD[i] = '0;
      if (inSync[i] != stableOut[i]) begin
        if (cntQ[i] == CntLast) begin
          stableD[i] = inSync[i];
          riseD[i]   = inSync[i];
          fallD[i]   = ~inSync[i];
        end else begin
          cntD[i] = cntQ[i] + CntW'(1);
        end
      end
    end
  end

  // Repeat FSM keys off the same-cycle acceptance so the first repeat lands HOLD_CYCLES after
  // the rise edge.
  always_comb begin
    repeatD = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      stateD[i] = stateQ[i];
      rptD[i]   = rptQ[i];
      if (!REPEAT_MASK[i]) begin
        stateD[i] = StIdle;
        rptD[i]   = '0;
      end else begin
        case (stateQ[i])
          StIdle: begin
            if (riseD[i]) begin
              stateD[i] = StHold;
              rptD[i]   = '0;
            end
          end
          StHold: begin
            if (fallD[i]) begin
              stateD[i] = StIdle;
              rptD[i]   = '0;
            end else if (rptQ[i] == HoldLast) begin
              repeatD[i] = 1'b1;
              rptD[i]    = '0;
              stateD[i]  = StRepeat;
            end else begin
              rptD[i] = rptQ[i] + RptW'(1);
            end
          end
          StRepeat: begin
            if (fallD[i]) begin
              stateD[i] = StIdle;
              rptD[i]   = '0;
            end else if (rptQ[i] == RepeatLast) begin
              repeatD[i] = 1'b1;
              rptD[i]    = '0;
            end else begin
              rptD[i] = rptQ[i] + RptW'(1);
            end
          end
          default: begin
            stateD[i] = StIdle;
            rptD[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stableOut   <= RESET_VALUE;
      risePulse   <= '0;
      fallPulse   <= '0;
      repeatPulse <= '0;
      anyChange   <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cntQ[i]   <= '0;
        rptQ[i]   <= '0;
        stateQ[i] <= StIdle;
      end
    end else begin
      stableOut   <= stableD;
      risePulse   <= riseD;
      fallPulse   <= fallD;
      repeatPulse <= repeatD;
      anyChange   <= |(riseD | fallD);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cntQ[i]   <= cntD[i];
        rptQ[i]   <= rptD[i];
        stateQ[i] <= stateD[i];
      end
    end
  end

endmodule
